// File: rtl/timer_array.sv
// timer_array: NCH independent down-counting timers behind a word-addressed
// bridge port. Each channel has CTRL / PRESET / COUNT registers, a sticky
// pending flag and a mask; irq[i] = PEND[i] & IM[i]. Reads are combinational.
//
// Optional build macro TIMER_PRESCALE_EN: register 3 of each channel becomes
// an 8-bit PRESCALE, and the counter steps once every PRESCALE+1 cycles.
// Without the macro, register 3 is reserved (reads 0, writes ignored).
//
// Per-channel FSM:
//   state  | meaning
//   IDLE   | waiting for EN; COUNT holds
//   LOAD   | COUNT <= PRESET
//   CNT    | counting down; !EN pauses back to IDLE with COUNT held
//   INT    | one cycle after expiry; one-shot drops EN, periodic reloads
module timer_array #(
    parameter int NCH    = 2,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NCH-1:0]    irq
);

    localparam int CH_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    logic [CH_W-1:0] chan;
    logic [1:0]      rsel;
    logic [31:0]     rd_ch [NCH];
    logic            unused_addr;

    assign chan        = addr[ADDR_W-1:4];
    assign rsel        = addr[3:2];
    assign unused_addr = ^addr[1:0];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state_q;
        logic             en_q;
        logic             im_q;
        logic             pend_q;
        logic             keep_en_q;
        logic [1:0]       mode_q;
        logic [WIDTH-1:0] preset_q;
        logic [WIDTH-1:0] count_q;
        logic             sel;
        logic             wr_ctrl;
        logic             wr_preset;
        logic             tick;
        logic             expire;
        logic [31:0]      rd_word;

        assign sel       = (chan == CH_W'(g));
        assign wr_ctrl   = we && sel && (rsel == 2'd0);
        assign wr_preset = we && sel && (rsel == 2'd1);

`ifdef TIMER_PRESCALE_EN
        logic [7:0] psc_q;
        logic [7:0] div_q;
        logic       wr_psc;

        assign wr_psc = we && sel && (rsel == 2'd3);
        assign tick   = (div_q == psc_q);

        // Prescale register and divider; the divider only runs while counting.
        always_ff @(posedge clk) begin
            if (reset) begin
                psc_q <= 8'd0;
                div_q <= 8'd0;
            end else begin
                if (wr_psc) begin
                    psc_q <= wdata[7:0];
                end
                if (state_q == S_CNT && en_q && !tick) begin
                    div_q <= div_q + 8'd1;
                end else begin
                    div_q <= 8'd0;
                end
            end
        end
`else
        assign tick = 1'b1;
`endif

        assign expire = (state_q == S_CNT) && en_q && tick && (count_q <= WIDTH'(1));

        // Channel FSM and registers; a CTRL write overrides EN/MODE/IM/PEND
        // on the same edge, while the FSM still follows its own transition.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= S_IDLE;
                en_q      <= 1'b0;
                im_q      <= 1'b0;
                pend_q    <= 1'b0;
                keep_en_q <= 1'b0;
                mode_q    <= 2'b00;
                preset_q  <= '0;
                count_q   <= '0;
            end else begin
                keep_en_q <= 1'b0;
                if (wr_preset) begin
                    preset_q <= wdata[WIDTH-1:0];
                end
                if (expire) begin
                    pend_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (en_q) begin
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        count_q <= preset_q;
                        state_q <= S_CNT;
                    end
                    S_CNT: begin
                        if (!en_q) begin
                            state_q <= S_IDLE;
                        end else if (tick) begin
                            if (count_q <= WIDTH'(1)) begin
                                count_q <= '0;
                                state_q <= S_INT;
                            end else begin
                                count_q <= count_q - WIDTH'(1);
                            end
                        end
                    end
                    S_INT: begin
                        state_q <= S_IDLE;
                        // A write that re-armed EN on the expiry edge keeps it.
                        if (mode_q != 2'b01 && !keep_en_q) begin
                            en_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
                if (wr_ctrl) begin
                    en_q      <= wdata[0];
                    mode_q    <= wdata[2:1];
                    im_q      <= wdata[3];
                    pend_q    <= 1'b0;
                    keep_en_q <= expire && wdata[0];
                end
            end
        end

        // Register read mux for this channel.
        always_comb begin
            rd_word = '0;
            case (rsel)
                2'd0:    rd_word = {27'd0, pend_q, im_q, mode_q, en_q};
                2'd1:    rd_word = 32'(preset_q);
                2'd2:    rd_word = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
                2'd3:    rd_word = {24'd0, psc_q};
`endif
                default: rd_word = '0;
            endcase
        end

        assign rd_ch[g] = rd_word;
        assign irq[g]   = pend_q & im_q;
    end

    // Channel select for read data; unmapped channels read zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan == CH_W'(i)) begin
                rdata = rd_ch[i];
            end
        end
    end

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array (NCH=2, WIDTH=32, ADDR_W=8).
module tb_timer_array;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr  = 8'h00;
    logic        we    = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [1:0]  irq;

    int cyc  = 0;
    int vecs = 0;
    int errs = 0;

    timer_array #(.NCH(2), .WIDTH(32), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Advance to 1 time unit after edge number n.
    task automatic tick_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write captured on the next rising edge; e returns that edge number.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, output int e);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        e  = cyc;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(8'(c * 16 + r * 4), v);
                vecs++;
                if (v !== 32'h0) begin
                    errs++;
                    $display("FAIL reset_reg ch%0d r%0d: got %h expected 0", c, r, v);
                end
            end
        end
        vecs++;
        if (irq !== 2'b00) begin
            errs++;
            $display("FAIL reset_irq: got %b expected 00", irq);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        int e, e0;
        wr(8'h04, 32'd5, e);
        wr(8'h00, 32'h9, e0);
        tick_to(e0 + 6);
        vecs++;
        if (irq[0] !== 1'b0) begin errs++; $display("FAIL oneshot_early: irq0=%b expected 0", irq[0]); end
        tick_to(e0 + 7);
        vecs++;
        if (irq[0] !== 1'b1) begin errs++; $display("FAIL oneshot_fire: irq0=%b expected 1", irq[0]); end
        tick_to(e0 + 10);
        vecs++;
        if (irq[0] !== 1'b1) begin errs++; $display("FAIL oneshot_sticky: irq0=%b expected 1", irq[0]); end
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h18) begin errs++; $display("FAIL oneshot_ctrl: got %h expected 18", v); end
        rd(8'h08, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL oneshot_count: got %h expected 0", v); end
        wr(8'h00, 32'h0, e);
        vecs++;
        if (irq[0] !== 1'b0) begin errs++; $display("FAIL oneshot_clear: irq0=%b expected 0", irq[0]); end
    endtask

    task automatic test_periodic;
        logic [31:0] v;
        logic [31:0] exp_cnt [4];
        int e, e0;
        exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0};
        wr(8'h14, 32'd3, e);
        wr(8'h10, 32'hB, e0);
        for (int k = 0; k < 4; k++) begin
            tick_to(e0 + 2 + k);
            rd(8'h18, v);
            vecs++;
            if (v !== exp_cnt[k]) begin
                errs++;
                $display("FAIL periodic_count E0+%0d: got %0d expected %0d", 2 + k, v, exp_cnt[k]);
            end
            if (k == 2 || k == 3) begin
                vecs++;
                if (irq[1] !== (k == 3)) begin
                    errs++;
                    $display("FAIL periodic_first E0+%0d: irq1=%b expected %b", 2 + k, irq[1], (k == 3));
                end
            end
        end
        tick_to(e0 + 6);
        wr(8'h10, 32'hB, e);
        vecs++;
        if (irq[1] !== 1'b0) begin errs++; $display("FAIL periodic_clear: irq1=%b expected 0", irq[1]); end
        tick_to(e0 + 8);
        rd(8'h18, v);
        vecs++;
        if (v !== 32'd3) begin errs++; $display("FAIL periodic_reload: got %0d expected 3", v); end
        tick_to(e0 + 10);
        vecs++;
        if (irq[1] !== 1'b0) begin errs++; $display("FAIL periodic_2nd_early: irq1=%b expected 0", irq[1]); end
        tick_to(e0 + 11);
        vecs++;
        if (irq[1] !== 1'b1) begin errs++; $display("FAIL periodic_2nd: irq1=%b expected 1", irq[1]); end
        tick_to(e0 + 12);
        wr(8'h10, 32'hB, e);
        tick_to(e0 + 16);
        vecs++;
        if (irq[1] !== 1'b0) begin errs++; $display("FAIL periodic_3rd_early: irq1=%b expected 0", irq[1]); end
        tick_to(e0 + 17);
        vecs++;
        if (irq !== 2'b10) begin errs++; $display("FAIL periodic_3rd: irq=%b expected 10", irq); end
        wr(8'h10, 32'h0, e);
    endtask

    task automatic test_pause;
        logic [31:0] v;
        int e, e0, r;
        wr(8'h04, 32'd10, e);
        wr(8'h00, 32'h9, e0);
        tick_to(e0 + 5);
        wr(8'h00, 32'h8, e);
        tick_to(e0 + 7);
        rd(8'h08, v);
        vecs++;
        if (v !== 32'd6) begin errs++; $display("FAIL pause_hold: got %0d expected 6", v); end
        tick_to(e0 + 10);
        rd(8'h08, v);
        vecs++;
        if (v !== 32'd6) begin errs++; $display("FAIL pause_hold_late: got %0d expected 6", v); end
        wr(8'h00, 32'h9, r);
        tick_to(r + 2);
        rd(8'h08, v);
        vecs++;
        if (v !== 32'd10) begin errs++; $display("FAIL pause_reload: got %0d expected 10", v); end
        tick_to(r + 3);
        wr(8'h04, 32'd2, e);
        tick_to(r + 5);
        rd(8'h08, v);
        vecs++;
        if (v !== 32'd7) begin errs++; $display("FAIL preset_midcount: got %0d expected 7", v); end
        tick_to(r + 11);
        vecs++;
        if (irq[0] !== 1'b0) begin errs++; $display("FAIL pause_early: irq0=%b expected 0", irq[0]); end
        tick_to(r + 12);
        vecs++;
        if (irq[0] !== 1'b1) begin errs++; $display("FAIL pause_fire: irq0=%b expected 1", irq[0]); end
        wr(8'h00, 32'h0, e);
    endtask

    task automatic test_collision;
        logic [31:0] v;
        int e, e0;
        wr(8'h04, 32'd1, e);
        wr(8'h00, 32'h9, e0);
        tick_to(e0 + 2);
        wr(8'h00, 32'h9, e);
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h9) begin errs++; $display("FAIL collide_ctrl: got %h expected 09", v); end
        tick_to(e0 + 4);
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h9) begin errs++; $display("FAIL collide_keep_en: got %h expected 09", v); end
        tick_to(e0 + 6);
        vecs++;
        if (irq[0] !== 1'b0) begin errs++; $display("FAIL collide_early: irq0=%b expected 0", irq[0]); end
        tick_to(e0 + 7);
        vecs++;
        if (irq[0] !== 1'b1) begin errs++; $display("FAIL collide_refire: irq0=%b expected 1", irq[0]); end
        tick_to(e0 + 9);
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h18) begin errs++; $display("FAIL collide_end: got %h expected 18", v); end
        wr(8'h00, 32'h0, e);
    endtask

    task automatic test_mask_unmapped;
        logic [31:0] v;
        logic [7:0]  unm [4];
        logic [31:0] exp_rsv;
        int e, e0, e1;
        unm = '{8'h20, 8'h24, 8'h2C, 8'hF0};
`ifdef TIMER_PRESCALE_EN
        exp_rsv = 32'hFF;
`else
        exp_rsv = 32'h0;
`endif
        wr(8'h04, 32'd2, e);
        wr(8'h10, 32'hB, e1);
        wr(8'h00, 32'h1, e0);
        tick_to(e0 + 3);
        vecs++;
        if (irq !== 2'b00) begin errs++; $display("FAIL mask_pre: irq=%b expected 00", irq); end
        tick_to(e0 + 4);
        vecs++;
        if (irq !== 2'b10) begin errs++; $display("FAIL mask_irq: irq=%b expected 10", irq); end
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h11) begin errs++; $display("FAIL mask_pend: got %h expected 11", v); end
        tick_to(e0 + 6);
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h10) begin errs++; $display("FAIL mask_ctrl_end: got %h expected 10", v); end
        rd(8'h03, v);
        vecs++;
        if (v !== 32'h10) begin errs++; $display("FAIL addr_lowbits: got %h expected 10", v); end
        for (int k = 0; k < 4; k++) begin
            rd(unm[k], v);
            vecs++;
            if (v !== 32'h0) begin errs++; $display("FAIL unmapped %h: got %h expected 0", unm[k], v); end
        end
        wr(8'h20, 32'h1F, e);
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h10) begin errs++; $display("FAIL unmapped_write: ch0 ctrl %h expected 10", v); end
        wr(8'h0C, 32'hFF, e);
        rd(8'h0C, v);
        vecs++;
        if (v !== exp_rsv) begin errs++; $display("FAIL reg3: got %h expected %h", v, exp_rsv); end
        wr(8'h10, 32'h0, e);
        wr(8'h00, 32'h0, e);
        wr(8'h0C, 32'h0, e);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic [7:0]  ra [4];
        int e, e0;
        ra = '{8'h00, 8'h04, 8'h08, 8'h14};
        wr(8'h04, 32'd10, e);
        wr(8'h10, 32'hB, e);
        wr(8'h00, 32'h9, e0);
        tick_to(e0 + 5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rd(ra[k], v);
            vecs++;
            if (v !== 32'h0) begin errs++; $display("FAIL reset_mid %h: got %h expected 0", ra[k], v); end
        end
        vecs++;
        if (irq !== 2'b00) begin errs++; $display("FAIL reset_mid_irq: irq=%b expected 00", irq); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rd(8'h00, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL reset_mid_idle: ctrl %h expected 0", v); end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale;
        logic [31:0] v;
        int e, e0;
        wr(8'h0C, 32'd3, e);
        wr(8'h04, 32'd4, e);
        rd(8'h0C, v);
        vecs++;
        if (v !== 32'd3) begin errs++; $display("FAIL prescale_reg: got %h expected 3", v); end
        wr(8'h00, 32'h9, e0);
        tick_to(e0 + 17);
        vecs++;
        if (irq[0] !== 1'b0) begin errs++; $display("FAIL prescale_early: irq0=%b expected 0", irq[0]); end
        tick_to(e0 + 18);
        vecs++;
        if (irq[0] !== 1'b1) begin errs++; $display("FAIL prescale_fire: irq0=%b expected 1", irq[0]); end
        wr(8'h00, 32'h0, e);
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_collision();
        test_mask_unmapped();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
- Parametrised multi-channel programmable timer on the CPU bridge; generalises the single-timer device the interrupt/exception CPU uses.
- Provides NCH independent down-counters with one-shot and periodic modes.
- Each channel has a sticky interrupt-pending flag and mask; `irq` feeds the CP0 hardware-interrupt inputs.
- Registers are word-addressed behind the bridge; reads are combinational.

Parameters:
- NCH, 2, number of timer channels (1..16).
- WIDTH, 32, counter/preset width in bits (1..32); wider fields read as zero-extended.
- ADDR_W, 8, byte-address width; NCH must be <= 2^(ADDR_W-4).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  byte address from bridge; bits [1:0] ignored.
- we  input  1  write strobe, sampled on rising clk.
- wdata  input  32  write data.
- rdata  output  32  combinational read data for addr.
- irq  output  NCH  per-channel interrupt request, irq[i] = PEND[i] & IM[i].

Behaviour:
- Decode: channel = addr[ADDR_W-1:4]; register = addr[3:2].
  - 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved (reads 0, writes ignored).
  - channel >= NCH is unmapped: rdata = 0, writes ignored.
- CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 periodic, 1x treated as one-shot), [3] IM, [4] PEND (read-only).
  - Bits [31:5] read 0.
  - Any CTRL write loads EN/MODE/IM and clears PEND.
- PRESET: R/W, WIDTH bits; a write mid-count takes effect only at the next LOAD.
- COUNT: current counter value; writes ignored.
- Reset: all CTRL/PRESET/COUNT/PEND = 0, all FSMs in IDLE, irq = 0, rdata reflects zeroed registers.
- Per-channel FSM: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, next = LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; next = CNT.
  - CNT: if !EN, next = IDLE and COUNT holds (pause/abort). Else if COUNT <= 1, COUNT <= 0, PEND <= 1, next = INT. Else COUNT <= COUNT-1.
  - INT: one cycle. One-shot: EN <= 0, next = IDLE. Periodic: next = IDLE (auto-reload via LOAD).
- Latency: CTRL write with EN=1, PRESET=P>=1, captured at edge E0 → PEND rises at edge E0+P+2.
  - PRESET=0 behaves as PRESET=1: PEND at E0+3.
  - Periodic period = P+3 cycles between PEND set events.
- PEND is sticky: stays 1 until a CTRL write or reset, regardless of further expiries.
- Simultaneous CTRL write and expiry on the same edge: the write wins.
  - PEND = 0, EN/MODE/IM take written values.
  - FSM follows the expiry transition (to INT), but one-shot EN clear is suppressed if the write set EN=1.
- Masking: IM=0 still sets PEND; irq stays 0. Setting IM later raises irq immediately on the next cycle if PEND=1 (a CTRL write clears PEND, so IM is normally written together with the clear).
- Channels fully independent; writes to one never disturb another.
- Reset mid-count returns every channel to IDLE with all registers zero on the next edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Enabled:
  - Register 3 becomes PRESCALE: R/W, bits [7:0], reset 0.
  - In CNT, the decrement/expiry check occurs only when an 8-bit per-channel divider reaches PRESCALE; otherwise COUNT holds and the divider increments.
  - The divider clears in LOAD, in IDLE, and on each decrement.
  - Expiry latency = E0 + 2 + P*(PRESCALE+1).
- Disabled: register 3 reserved as above; decrement every CNT cycle.

Test Plan:
- Reset, then read all mapped registers → all 0; irq = 0.
- Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at edge E0 → irq[0] rises at E0+7, stays high.
  - CTRL reads 0x18 (EN cleared, IM, PEND); COUNT = 0.
  - Writing CTRL=0 drops irq[0] next cycle.
- Ch1 PRESET=3, CTRL=0xB (periodic, IM) → PEND set at E0+5, E0+11, E0+17. COUNT sequence 3,2,1,0 repeats.
- Ch0 PRESET=10 running, write CTRL=0x8 (EN=0) after 4 decrements → COUNT holds at 6.
  - Re-enable → reload to 10, expiry 12 edges later.
- IM=0 one-shot PRESET=2 → PEND=1 with irq=0. Ch1 activity unaffected. Address with channel >= NCH reads 0.
- Bonus, with TIMER_PRESCALE_EN: PRESCALE=3, PRESET=4 → PEND at E0+18.
